// File: rtl/usb_host_arb_pkg.sv
// Shared types and constants for the USB host register-port arbiter.
//   arbState_t   : arbiter FSM states
//   regReq_t     : one requester's register access payload (address/data/we)
//   TIMEOUT_DATA : read data returned on a watchdog completion
//   REQ_CPU/REQ_SCHED : requester indices (bit positions in req/gnt/owner vectors)
package usb_host_arb_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;

  localparam int unsigned REQ_CPU   = 0;
  localparam int unsigned REQ_SCHED = 1;

  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arbState_t;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              we;
  } regReq_t;

endpackage

// File: rtl/usb_arb_rr2.sv
// Two-way round-robin pick with lock mask (purely combinational).
//   req        : request vector, bit i = requester i
//   last_grant : index of the requester served last; the other one wins a tie
//   lock_valid : a lock owner exists, only it may be granted
//   lock_id    : index of the lock owner
//   gnt        : one-hot grant, 00 when nobody is eligible
module usb_arb_rr2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       lock_valid,
  input  logic       lock_id,
  output logic [1:0] gnt
);

  logic [1:0] eligible;

  // Mask by lock owner, then resolve a tie against the last winner.
  always_comb begin
    eligible = req;
    if (lock_valid) begin
      eligible = lock_id ? (req & 2'b10) : (req & 2'b01);
    end
    gnt = 2'b00;
    case (eligible)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/usb_host_reg_arbiter.sv
// Shares the USB host core's 8-bit strobe/ack register port between the CPU
// bridge (m0) and the transfer scheduler (m1). Round-robin with optional bus
// lock; a watchdog completes unacked accesses with err=1 and data 8'hFF.
//   clk_i, rst_i (async, active-low)
//   m0_*/m1_* : requester ports (address, data, we, strobe, lock in; data, ack, err out)
//   s_*       : host core register port (address, data, we, strobe out; data, ack in)
//   owner_o   : one-hot current owner, 00 when idle and unlocked
module usb_host_reg_arbiter
  import usb_host_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TO_CNT_WIDTH   = 7
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] m0_address_i,
  input  logic [7:0] m0_data_i,
  output logic [7:0] m0_data_o,
  input  logic       m0_we_i,
  input  logic       m0_strobe_i,
  input  logic       m0_lock_i,
  output logic       m0_ack_o,
  output logic       m0_err_o,
  input  logic [7:0] m1_address_i,
  input  logic [7:0] m1_data_i,
  output logic [7:0] m1_data_o,
  input  logic       m1_we_i,
  input  logic       m1_strobe_i,
  input  logic       m1_lock_i,
  output logic       m1_ack_o,
  output logic       m1_err_o,
  output logic [7:0] s_address_o,
  output logic [7:0] s_data_o,
  input  logic [7:0] s_data_i,
  output logic       s_we_o,
  output logic       s_strobe_o,
  input  logic       s_ack_i,
  output logic [1:0] owner_o
);

  arbState_t              state, stateNext;
  regReq_t                sReq, sReqNext;
  regReq_t                m0Req, m1Req;
  logic                   sStrobe, sStrobeNext;
  logic [1:0]             owner, ownerNext;
  logic                   lastGrant, lastGrantNext;
  logic                   lockValid, lockValidNext;
  logic                   lockId, lockIdNext;
  logic [TO_CNT_WIDTH-1:0] toCnt, toCntNext;
  logic                   m0Ack, m0AckNext, m0Err, m0ErrNext;
  logic                   m1Ack, m1AckNext, m1Err, m1ErrNext;
  logic [7:0]             m0Data, m0DataNext, m1Data, m1DataNext;
  logic [1:0]             gnt;
  logic                   timeoutHit;
  logic                   ownerLock;
  logic                   lockHolderLock;

  assign m0Req = '{address: m0_address_i, data: m0_data_i, we: m0_we_i};
  assign m1Req = '{address: m1_address_i, data: m1_data_i, we: m1_we_i};

  assign timeoutHit     = (toCnt == TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  // lastGrant always names the owner of the access in flight / just completed.
  assign ownerLock      = lastGrant ? m1_lock_i : m0_lock_i;
  assign lockHolderLock = lockId ? m1_lock_i : m0_lock_i;

  usb_arb_rr2 u_rr2 (
    .req        ({m1_strobe_i, m0_strobe_i}),
    .last_grant (lastGrant),
    .lock_valid (lockValid),
    .lock_id    (lockId),
    .gnt        (gnt)
  );

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      sReq      <= '0;
      sStrobe   <= 1'b0;
      owner     <= 2'b00;
      lastGrant <= 1'b1;
      lockValid <= 1'b0;
      lockId    <= 1'b0;
      toCnt     <= '0;
      m0Ack     <= 1'b0;
      m0Err     <= 1'b0;
      m0Data    <= '0;
      m1Ack     <= 1'b0;
      m1Err     <= 1'b0;
      m1Data    <= '0;
    end else begin
      state     <= stateNext;
      sReq      <= sReqNext;
      sStrobe   <= sStrobeNext;
      owner     <= ownerNext;
      lastGrant <= lastGrantNext;
      lockValid <= lockValidNext;
      lockId    <= lockIdNext;
      toCnt     <= toCntNext;
      m0Ack     <= m0AckNext;
      m0Err     <= m0ErrNext;
      m0Data    <= m0DataNext;
      m1Ack     <= m1AckNext;
      m1Err     <= m1ErrNext;
      m1Data    <= m1DataNext;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    stateNext     = state;
    sReqNext      = sReq;
    sStrobeNext   = sStrobe;
    ownerNext     = owner;
    lastGrantNext = lastGrant;
    lockValidNext = lockValid;
    lockIdNext    = lockId;
    toCntNext     = toCnt;
    m0AckNext     = 1'b0;
    m0ErrNext     = 1'b0;
    m0DataNext    = '0;
    m1AckNext     = 1'b0;
    m1ErrNext     = 1'b0;
    m1DataNext    = '0;

    unique case (state)
      IDLE: begin
        if (gnt != 2'b00) begin
          lastGrantNext = gnt[REQ_SCHED];
          sReqNext      = gnt[REQ_SCHED] ? m1Req : m0Req;
          sStrobeNext   = 1'b1;
          ownerNext     = gnt;
          toCntNext     = '0;
          stateNext     = ACCESS;
        end else if (lockValid && !lockHolderLock) begin
          // Lock holder let go while idle without a request.
          lockValidNext = 1'b0;
          ownerNext     = 2'b00;
        end
      end
      ACCESS: begin
        toCntNext = toCnt + TO_CNT_WIDTH'(1);
        // A real ack beats a coincident timeout.
        if (s_ack_i || timeoutHit) begin
          sStrobeNext = 1'b0;
          stateNext   = DONE;
          if (lastGrant) begin
            m1AckNext  = 1'b1;
            m1ErrNext  = !s_ack_i;
            m1DataNext = s_ack_i ? s_data_i : TIMEOUT_DATA;
          end else begin
            m0AckNext  = 1'b1;
            m0ErrNext  = !s_ack_i;
            m0DataNext = s_ack_i ? s_data_i : TIMEOUT_DATA;
          end
        end
      end
      DONE: begin
        stateNext = IDLE;
        if (ownerLock) begin
          lockValidNext = 1'b1;
          lockIdNext    = lastGrant;
        end else begin
          lockValidNext = 1'b0;
          ownerNext     = 2'b00;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign s_address_o = sReq.address;
  assign s_data_o    = sReq.data;
  assign s_we_o      = sReq.we;
  assign s_strobe_o  = sStrobe;
  assign owner_o     = owner;
  assign m0_ack_o    = m0Ack;
  assign m0_err_o    = m0Err;
  assign m0_data_o   = m0Data;
  assign m1_ack_o    = m1Ack;
  assign m1_err_o    = m1Err;
  assign m1_data_o   = m1Data;

endmodule

// File: tb/tb_usb_host_reg_arbiter.sv
// Scoreboard bench for usb_host_reg_arbiter: requester tasks push expected
// completions, a host model answers the s_* port, and a negedge monitor pops
// and compares completions, checks the s_* payload and the grant order.
module tb_usb_host_reg_arbiter;

  localparam int unsigned TIMEOUT = 64;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] m0_address_i, m0_data_i, m0_data_o;
  logic       m0_we_i, m0_strobe_i, m0_lock_i, m0_ack_o, m0_err_o;
  logic [7:0] m1_address_i, m1_data_i, m1_data_o;
  logic       m1_we_i, m1_strobe_i, m1_lock_i, m1_ack_o, m1_err_o;
  logic [7:0] s_address_o, s_data_o, s_data_i;
  logic       s_we_o, s_strobe_o, s_ack_i;
  logic [1:0] owner_o;

  usb_host_reg_arbiter #(.TIMEOUT_CYCLES(TIMEOUT), .TO_CNT_WIDTH(7)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_address_i(m0_address_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
    .m0_we_i(m0_we_i), .m0_strobe_i(m0_strobe_i), .m0_lock_i(m0_lock_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_address_i(m1_address_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
    .m1_we_i(m1_we_i), .m1_strobe_i(m1_strobe_i), .m1_lock_i(m1_lock_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_address_o(s_address_o), .s_data_o(s_data_o), .s_data_i(s_data_i),
    .s_we_o(s_we_o), .s_strobe_o(s_strobe_o), .s_ack_i(s_ack_i),
    .owner_o(owner_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic err; logic [7:0] data; } exp_t;

  exp_t       q0[$], q1[$];
  logic [16:0] curReq [2];
  int         grantLog[$];
  int         errors = 0, checks = 0;
  int         hostDelayMode = -1;     // -1: random 0..4, addr 8'hEE never acked
  logic [8:0] hostDataOvr = '0;       // bit 8 set: host returns [7:0]
  logic       abortAll = 1'b0;
  int         lastServed = 1, lockModel = -1;
  int         hostWait = 0, hostDelay = 0;
  logic       hostAcked = 1'b0;

  function automatic logic [7:0] hostResp(input logic [7:0] a, input logic [7:0] d, input logic w);
    return a ^ {d[6:0], d[7]} ^ {7'd0, w} ^ 8'h3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int id, input logic s, input logic [7:0] a, input logic [7:0] d,
                       input logic w, input logic lk);
    if (id == 0) begin
      m0_strobe_i = s; m0_address_i = a; m0_data_i = d; m0_we_i = w; m0_lock_i = lk;
    end else begin
      m1_strobe_i = s; m1_address_i = a; m1_data_i = d; m1_we_i = w; m1_lock_i = lk;
    end
  endtask

  // One access: push expectation, hold strobe until ack, drop it, leave one gap cycle.
  // Called and returns #1 after a rising edge; lat counts edges from request to ack.
  task automatic issue(input int id, input logic [7:0] a, input logic [7:0] d,
                       input logic w, input logic lk, output int lat);
    exp_t e;
    logic got;
    int   n;
    e.err  = (hostDelayMode >= 0) ? (hostDelayMode >= int'(TIMEOUT)) : (a == 8'hEE);
    e.data = e.err ? 8'hFF : (hostDataOvr[8] ? hostDataOvr[7:0] : hostResp(a, d, w));
    if (id == 0) q0.push_back(e); else q1.push_back(e);
    curReq[id] = {a, d, w};
    drive(id, 1'b1, a, d, w, lk);
    got = 1'b0;
    n = 0;
    while (!got && !abortAll && n < 400) begin
      @(posedge clk_i); #1;
      n++;
      got = (id == 0) ? m0_ack_o : m1_ack_o;
    end
    drive(id, 1'b0, a, d, w, lk);
    if (!abortAll) chk("ack_seen", 32'(got), 32'd1);
    lat = n;
    @(posedge clk_i); #1;
  endtask

  task automatic randAgent(input int id, input int count);
    int lat;
    logic [7:0] a;
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk_i); #1; end
      a = ($urandom_range(0, 7) == 0) ? 8'hEE : 8'($urandom);
      issue(id, a, 8'($urandom), 1'($urandom), 1'b0, lat);
      chk("min_latency", 32'(lat >= 2), 32'd1);
    end
  endtask

  // Host core model: acks hostDelay cycles into the access, spurious acks while idle.
  initial begin : host
    s_ack_i = 1'b0;
    s_data_i = 8'h00;
    forever begin
      @(posedge clk_i); #1;
      s_ack_i = 1'b0;
      s_data_i = 8'($urandom);
      if (s_strobe_o === 1'b1 && !hostAcked) begin
        if (hostWait == 0)
          hostDelay = (hostDelayMode >= 0) ? hostDelayMode
                    : ((s_address_o == 8'hEE) ? 1000 : int'($urandom_range(0, 4)));
        if (hostWait == hostDelay) begin
          s_ack_i = 1'b1;
          s_data_i = hostDataOvr[8] ? hostDataOvr[7:0] : hostResp(s_address_o, s_data_o, s_we_o);
          hostAcked = 1'b1;
        end
        hostWait++;
      end else if (s_strobe_o === 1'b0) begin
        hostWait = 0;
        hostAcked = 1'b0;
        s_ack_i = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: completions against scoreboard, payload against owner, grant against model.
  initial begin : monitor
    logic       prevStrobe;
    logic [1:0] prevReq, elig;
    logic       ack, err;
    logic [7:0] data;
    exp_t       e;
    int         win, qn;
    prevStrobe = 1'b0;
    prevReq = 2'b00;
    forever begin
      @(negedge clk_i);
      if (rst_i !== 1'b1) begin
        q0.delete(); q1.delete();
        lastServed = 1; lockModel = -1;
        prevStrobe = 1'b0; prevReq = 2'b00;
        continue;
      end
      chk("ack_onehot", 32'(m0_ack_o & m1_ack_o), 32'd0);
      for (int id = 0; id < 2; id++) begin
        ack  = (id == 0) ? m0_ack_o : m1_ack_o;
        err  = (id == 0) ? m0_err_o : m1_err_o;
        data = (id == 0) ? m0_data_o : m1_data_o;
        qn   = (id == 0) ? q0.size() : q1.size();
        if (ack) begin
          chk("ack_pending", 32'(qn != 0), 32'd1);
          if (qn != 0) begin
            e = (id == 0) ? q0.pop_front() : q1.pop_front();
            chk("ack_data", 32'(data), 32'(e.data));
            chk("ack_err", 32'(err), 32'(e.err));
          end
          lockModel = (((id == 0) ? m0_lock_i : m1_lock_i) == 1'b1) ? id : -1;
        end else begin
          chk("idle_quiet", 32'({err, data}), 32'd0);
        end
      end
      if (s_strobe_o) begin
        chk("owner_onehot", 32'($onehot(owner_o)), 32'd1);
        chk("s_payload", 32'({s_address_o, s_data_o, s_we_o}), 32'(curReq[owner_o[1]]));
      end
      if (s_strobe_o && !prevStrobe) begin
        elig = prevReq;
        if (lockModel >= 0) elig = elig & ((lockModel == 1) ? 2'b10 : 2'b01);
        win = (elig == 2'b11) ? (1 - lastServed) : ((elig == 2'b10) ? 1 : 0);
        chk("grant_had_req", 32'(elig != 2'b00), 32'd1);
        chk("grant_owner", 32'(owner_o), (win == 1) ? 32'd2 : 32'd1);
        lastServed = win;
        grantLog.push_back(int'(owner_o[1]));
      end
      prevStrobe = s_strobe_o;
      prevReq = {m1_strobe_i, m0_strobe_i};
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int lat;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    curReq[0] = '0;
    curReq[1] = '0;
    #2 rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_outputs", 32'({s_strobe_o, owner_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o,
                             m0_data_o, m1_data_o, s_we_o}), 32'd0);
    chk("reset_sbus", 32'({s_address_o, s_data_o}), 32'd0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("post_reset_idle", 32'({s_strobe_o, owner_o}), 32'd0);

    // Simultaneous requests from reset alternate 0,1,0,1,...
    hostDelayMode = 1;
    grantLog.delete();
    for (int r = 0; r < 3; r++) begin
      fork
        begin int l0; issue(0, 8'(8'h10 + r), 8'hA0, 1'b1, 1'b0, l0); end
        begin int l1; issue(1, 8'(8'h20 + r), 8'hB0, 1'b0, 1'b0, l1); end
      join
    end
    chk("tie_count", 32'(grantLog.size()), 32'd6);
    for (int i = 0; i < grantLog.size(); i++) chk("tie_order", 32'(grantLog[i]), 32'(i % 2));

    // Single read, host acks 3 cycles into the access with 8'h5A.
    hostDelayMode = 3;
    hostDataOvr = 9'h15A;
    issue(0, 8'h04, 8'h00, 1'b0, 1'b0, lat);
    chk("single_latency", 32'(lat), 32'd5);
    chk("single_owner_after", 32'(owner_o), 32'd0);
    hostDataOvr = '0;

    // m1 holds the lock over three accesses while m0 waits.
    hostDelayMode = 1;
    grantLog.delete();
    fork
      begin
        int l;
        issue(1, 8'h00, 8'h11, 1'b1, 1'b1, l);
        issue(1, 8'h01, 8'h22, 1'b1, 1'b1, l);
        issue(1, 8'h02, 8'h33, 1'b1, 1'b0, l);
      end
      begin
        int l;
        repeat (2) begin @(posedge clk_i); #1; end
        issue(0, 8'h50, 8'h44, 1'b0, 1'b0, l);
      end
    join
    chk("lock_count", 32'(grantLog.size()), 32'd4);
    for (int i = 0; i < grantLog.size(); i++)
      chk("lock_order", 32'(grantLog[i]), (i < 3) ? 32'd1 : 32'd0);

    // Host never acks: watchdog completion.
    hostDelayMode = 1000;
    issue(0, 8'h30, 8'hC3, 1'b1, 1'b0, lat);
    chk("timeout_latency", 32'(lat), 32'(TIMEOUT + 1));
    chk("timeout_strobe_low", 32'(s_strobe_o), 32'd0);

    // Ack arrives exactly on the last counter value: ack wins.
    hostDelayMode = int'(TIMEOUT) - 1;
    issue(1, 8'h31, 8'h5C, 1'b0, 1'b0, lat);
    chk("coincide_latency", 32'(lat), 32'(TIMEOUT + 1));

    // Randomized traffic from both requesters.
    hostDelayMode = -1;
    fork
      randAgent(0, 30);
      randAgent(1, 30);
    join

    // Asynchronous reset in the middle of an access.
    hostDelayMode = 1000;
    fork
      begin int l; issue(0, 8'h40, 8'h01, 1'b0, 1'b0, l); end
      begin
        repeat (10) begin @(posedge clk_i); #1; end
        @(negedge clk_i); #2;
        chk("pre_reset_strobe", 32'(s_strobe_o), 32'd1);
        rst_i = 1'b0;
        abortAll = 1'b1;
        #1;
        chk("rst_strobe_drop", 32'(s_strobe_o), 32'd0);
        chk("rst_owner_drop", 32'(owner_o), 32'd0);
        chk("rst_no_ack", 32'({m0_ack_o, m1_ack_o}), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        abortAll = 1'b0;
      end
    join
    hostDelayMode = 2;
    grantLog.delete();
    issue(1, 8'h41, 8'h02, 1'b1, 1'b0, lat);
    chk("post_rst_latency", 32'(lat), 32'd4);
    chk("post_rst_grants", 32'(grantLog.size()), 32'd1);
    if (grantLog.size() > 0) chk("post_rst_owner", 32'(grantLog[0]), 32'd1);

    repeat (5) @(posedge clk_i);
    #1;
    chk("queues_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_host_reg_arbiter.md
Name: usb_host_reg_arbiter

Overview:
- Two-requester arbiter that shares the single 8-bit strobe/ack register port of the USB host core.
- Requester 0 is the CPU bus bridge; requester 1 is the transfer scheduler.
- Arbitration is round-robin, with optional per-requester bus lock for atomic register sequences.
- A watchdog completes any access that the host never acks, returning an error.

Parameters:
- TIMEOUT_CYCLES, 64: cycles in ACCESS without s_ack_i before an error completion is forced (minimum 2).
- TO_CNT_WIDTH, 7: width of the timeout counter; must satisfy 2^TO_CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  single system clock; all logic is on its rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- m0_address_i  in  8  requester 0 register address.
- m0_data_i  in  8  requester 0 write data.
- m0_data_o  out  8  requester 0 read data; valid while m0_ack_o=1.
- m0_we_i  in  1  requester 0 write enable.
- m0_strobe_i  in  1  requester 0 access request.
- m0_lock_i  in  1  requester 0 keeps ownership after the current access.
- m0_ack_o  out  1  requester 0 one-cycle completion pulse.
- m0_err_o  out  1  requester 0 timeout flag; qualified by m0_ack_o.
- m1_*  same eight signals for requester 1.
- s_address_o  out  8  address to host core.
- s_data_o  out  8  write data to host core.
- s_data_i  in  8  read data from host core.
- s_we_o  out  1  write enable to host core.
- s_strobe_o  out  1  access strobe to host core.
- s_ack_i  in  1  host core acknowledge.
- owner_o  out  2  one-hot current owner; 00 when idle and unlocked.

Behaviour:
- Reset (rst_i=0), applied asynchronously:
  - State IDLE; all outputs 0; last_grant=1, so requester 0 wins the first tie; lock owner cleared; timeout counter 0.
  - Reset mid-access drops s_strobe_o immediately and no ack is issued.
- Requester rules:
  - Hold address/data/we stable and strobe high until ack.
  - Drop strobe in the cycle after ack.
  - A strobe still high in the cycle after ack is treated as a new request.
- IDLE:
  - If a lock owner is set, only that requester is eligible.
  - Otherwise a single requester wins; if both request, the requester not equal to last_grant wins.
  - On grant, register that requester's address/data/we onto s_* and set s_strobe_o=1 at the next edge. Grant-to-strobe latency is 1 cycle.
  - owner_o updates on the same edge; last_grant is updated.
- ACCESS:
  - s_strobe_o is held; the counter increments each cycle.
  - On s_ack_i=1:
    - At the next edge, pulse the owner's ack for 1 cycle with data_o=s_data_i (registered) and err=0.
    - Clear s_strobe_o on the same edge; go to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 and s_ack_i=0:
    - Pulse ack with err=1 and data_o=8'hFF; clear s_strobe_o; go to DONE.
  - If s_ack_i and timeout coincide, the ack wins (err=0).
- DONE (1 cycle):
  - Sample the owner's lock_i. If 1, keep the lock owner and owner_o; otherwise clear both.
  - Go to IDLE.
  - Minimum turnaround is strobe→ack 1 cycle, ack→next strobe 2 cycles.
- Lock:
  - The other requester waits indefinitely while a lock is held.
  - If the lock owner drops lock_i while idle with no strobe, the lock is released in IDLE on the next cycle.
- Other rules:
  - s_ack_i outside ACCESS is ignored.
  - The non-owner's ack_o, err_o and data_o stay 0.
  - The counter clears on entry to ACCESS.

Decomposition:
- Shared package usb_host_arb_pkg:
  - State enum {IDLE, ACCESS, DONE}.
  - Constant TIMEOUT_DATA=8'hFF.
  - Requester index localparams REQ_CPU=0, REQ_SCHED=1.
- Sub-module usb_arb_rr2: 2-way round-robin pick with lock mask.
  - Inputs: req[1:0], last_grant, lock_valid, lock_id.
  - Outputs: gnt[1:0] (combinational).
- Top level holds the FSM, output registers and timeout counter.

Test Plan:
- Single read: m0 strobe, addr 8'h04; host acks 3 cycles after s_strobe_o with data 8'h5A → m0_ack_o one cycle, m0_data_o=8'h5A, m0_err_o=0, owner_o=01 then 00.
- Tie: m0 and m1 strobe on the same cycle from reset → m0 served first, then m1; repeated simultaneous requests alternate 0,1,0,1.
- Lock: m1 writes addr 8'h00 with m1_lock_i=1 while m0 strobes → m1 completes two more accesses before m0; m0 is granted 1 cycle after m1 drops lock in DONE.
- Timeout: host never acks on m0 write with TIMEOUT_CYCLES=64 → m0_ack_o and m0_err_o at cycle 64 after strobe, m0_data_o=8'hFF, s_strobe_o low.
- Ack and timeout coincide: s_ack_i=1 exactly at count 63 → err=0 and data taken from s_data_i.
- Reset mid-ACCESS: assert rst_i=0 asynchronously → s_strobe_o and owner_o drop before the next edge, no ack pulses; after release, m1 alone is granted normally.
